// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : unified_mem_arbiter
// Purpose : Shares one variable-latency memory between instruction fetch and
//           the MEM-stage data port; data has priority, fetch has anti-starve.
// Revision: 1.0 - initial release
// ============================================================================
module unified_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              dm_stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              bus_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [TW-1:0] TMO_LIM    = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;      // 1 = data port owns the access
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic              mem_req_q, mem_req_d;
    logic              bus_err_q, bus_err_d;
    logic              if_ready_q, if_ready_d;
    logic              dm_ready_q, dm_ready_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic [DATA_W-1:0] rdata_w;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        starve_d   = starve_q;
        tmo_d      = tmo_q;
        mem_req_d  = mem_req_q;
        bus_err_d  = bus_err_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_ready_d = 1'b0;
        dm_ready_d = 1'b0;
        rdata_w    = we_q ? '0 : mem_rdata;

        case (state_q)
            IDLE: begin
                if (dm_req && !(if_req && (starve_q == STARVE_LIM))) begin
                    owner_d   = 1'b1;
                    we_d      = dm_we;
                    addr_d    = dm_addr;
                    wdata_d   = dm_wdata;
                    mem_req_d = 1'b1;
                    tmo_d     = '0;
                    state_d   = ACC;
                    if (!if_req)
                        starve_d = '0;
                    else if (starve_q != STARVE_LIM)
                        starve_d = starve_q + SW'(1);
                end else if (if_req) begin
                    owner_d   = 1'b0;
                    we_d      = 1'b0;
                    addr_d    = if_addr;
                    wdata_d   = '0;
                    mem_req_d = 1'b1;
                    tmo_d     = '0;
                    starve_d  = '0;
                    state_d   = ACC;
                end
            end
            ACC: begin
                tmo_d = tmo_q + TW'(1);
                if (mem_ack || (tmo_d == TMO_LIM)) begin
                    // An expired access completes with zero data and a sticky error
                    if (!mem_ack) begin
                        bus_err_d = 1'b1;
                        rdata_w   = '0;
                    end
                    if (owner_q) begin
                        dm_rdata_d = rdata_w;
                        dm_ready_d = 1'b1;
                    end else begin
                        if_rdata_d = rdata_w;
                        if_ready_d = 1'b1;
                    end
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                    state_d   = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            starve_q   <= '0;
            tmo_q      <= '0;
            mem_req_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            starve_q   <= starve_d;
            tmo_q      <= tmo_d;
            mem_req_q  <= mem_req_d;
            bus_err_q  <= bus_err_d;
            if_ready_q <= if_ready_d;
            dm_ready_q <= dm_ready_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign bus_err   = bus_err_q;
    assign if_ready  = if_ready_q;
    assign dm_ready  = dm_ready_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign if_stall  = if_req & ~if_ready_q;
    assign dm_stall  = dm_req & ~dm_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_unified_mem_arbiter
// Purpose : Directed self-checking bench for unified_mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        if_stall;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        dm_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        bus_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
        .if_ready(if_ready), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .bus_err(bus_err)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a == 32'h40) ? 32'h2008_0005 : (a ^ 32'h5A5A_0000);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Memory responder: ack ack_lat cycles after mem_req rises
    int ack_lat = 0;
    bit ack_en  = 1'b1;
    int acc_cnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            if (ack_en && acc_cnt == ack_lat) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_f(mem_addr);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hBAD0_0000;
            end
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            mem_ack = 1'b0;
        end
    end

    logic [31:0] grants[$];
    logic        mreq_prev = 1'b0;
    always @(negedge clk) begin
        if (mem_req && !mreq_prev) grants.push_back(mem_addr);
        mreq_prev = mem_req;
    end

    // sel: 0 = mem_req, 1 = if_ready, 2 = dm_ready; cyc = -1 on expiry
    task automatic wait_for(input int sel, input int budget, output int cyc);
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((sel == 0 && mem_req) || (sel == 1 && if_ready) || (sel == 2 && dm_ready)) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, d_at, i_at, acc;
        bit hold_ok;
        logic [31:0] exp_a;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_mem_req", mem_req, 0);
        check("rst_if_ready", if_ready, 0);
        check("rst_dm_ready", dm_ready, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_if_rdata", if_rdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // Lone fetch, ack 2 cycles after mem_req
        ack_lat = 2;
        if_addr = 32'h40;
        if_req  = 1'b1;
        #1 check("fetch_stall", if_stall, 1);
        wait_for(0, 20, c);
        check("fetch_grant_lat", c, 1);
        check("fetch_mem_addr", mem_addr, 32'h40);
        check("fetch_mem_we", mem_we, 0);
        check("fetch_stall_acc", if_stall, 1);
        wait_for(1, 20, c);
        check("fetch_ready_lat", c, 3);
        check("fetch_rdata", if_rdata, 32'h2008_0005);
        check("fetch_stall_rdy", if_stall, 0);
        if_req = 1'b0;
        @(negedge clk);
        check("fetch_pulse_1cyc", if_ready, 0);
        check("fetch_idle_mreq", mem_req, 0);

        // Collision: data first, then fetch
        ack_lat = 0;
        grants.delete();
        d_at = -1;
        i_at = -1;
        if_addr = 32'h40;
        dm_addr = 32'h100;
        dm_we   = 1'b0;
        if_req  = 1'b1;
        dm_req  = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (dm_ready) begin
                d_at = i;
                check("coll_dm_rdata", dm_rdata, 32'h5A5A_0100);
                dm_req = 1'b0;
            end
            if (if_ready) begin
                i_at = i;
                check("coll_if_rdata", if_rdata, 32'h2008_0005);
                if_req = 1'b0;
            end
            if (d_at > 0 && i_at > 0) break;
        end
        check("coll_dm_ready_at", d_at, 2);
        check("coll_if_ready_at", i_at, 5);
        check("coll_grant_cnt", grants.size(), 2);
        if (grants.size() >= 2) begin
            check("coll_grant0", grants[0], 32'h100);
            check("coll_grant1", grants[1], 32'h40);
        end

        // Starvation: D,D,D,D,I,D,D,D,D,I
        @(negedge clk);
        grants.delete();
        if_req = 1'b1;
        dm_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (grants.size() >= 10) break;
        end
        if_req = 1'b0;
        dm_req = 1'b0;
        check("starve_grant_cnt", grants.size() >= 10, 1);
        for (int i = 0; i < 10 && i < grants.size(); i++) begin
            exp_a = (i == 4 || i == 9) ? 32'h40 : 32'h100;
            check($sformatf("starve_grant%0d", i), grants[i], exp_a);
        end
        repeat (6) @(negedge clk);

        // Write: latched values held for the whole access
        ack_lat  = 3;
        dm_we    = 1'b1;
        dm_addr  = 32'h8;
        dm_wdata = 32'hDEAD_BEEF;
        dm_req   = 1'b1;
        wait_for(0, 20, c);
        check("wr_grant_lat", c, 1);
        hold_ok = 1'b1;
        acc = 0;
        do begin
            acc++;
            if (mem_we !== 1'b1 || mem_addr !== 32'h8 || mem_wdata !== 32'hDEAD_BEEF) hold_ok = 1'b0;
            @(negedge clk);
        end while (mem_req && acc < 20);
        check("wr_hold", hold_ok, 1);
        check("wr_acc_cycles", acc, 4);
        check("wr_dm_ready", dm_ready, 1);
        check("wr_dm_rdata", dm_rdata, 0);
        dm_req = 1'b0;
        dm_we  = 1'b0;
        @(negedge clk);

        // Timeout: no ack for a fetch
        ack_en  = 1'b0;
        if_addr = 32'h80;
        if_req  = 1'b1;
        wait_for(0, 20, c);
        check("tmo_grant_lat", c, 1);
        check("tmo_err_early", bus_err, 0);
        acc = 0;
        do begin
            acc++;
            @(negedge clk);
        end while (mem_req && acc < 40);
        check("tmo_acc_cycles", acc, 8);
        check("tmo_if_ready", if_ready, 1);
        check("tmo_if_rdata", if_rdata, 0);
        check("tmo_bus_err", bus_err, 1);
        if_req = 1'b0;
        ack_en = 1'b1;
        ack_lat = 1;
        @(negedge clk);
        dm_addr = 32'h100;
        dm_req  = 1'b1;
        wait_for(2, 30, c);
        check("tmo_next_lat", c, 3);
        check("tmo_next_rdata", dm_rdata, 32'h5A5A_0100);
        check("tmo_err_sticky", bus_err, 1);
        dm_req = 1'b0;
        @(negedge clk);

        // Reset during an access
        ack_en  = 1'b0;
        if_addr = 32'h40;
        if_req  = 1'b1;
        wait_for(0, 20, c);
        check("rsta_grant_lat", c, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rsta_mem_req", mem_req, 0);
        check("rsta_bus_err", bus_err, 0);
        check("rsta_if_ready", if_ready, 0);
        check("rsta_if_rdata", if_rdata, 0);
        repeat (2) @(negedge clk);
        check("rsta_no_ready", if_ready, 0);
        rst = 1'b0;
        ack_en = 1'b1;
        ack_lat = 1;
        wait_for(1, 20, c);
        check("rsta_fetch_lat", c, 3);
        check("rsta_fetch_rdata", if_rdata, 32'h2008_0005);
        if_req = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port, variable-latency memory between the pipeline's instruction-fetch port and its MEM-stage data port.
- Replaces the separate instruction and data memories when the CPU moves to a unified memory.
- Serialises accesses and returns per-port ready pulses with registered read data.
- Drives stall outputs that the hazard logic ORs into IF_Stall, ID_Stall and the EX/MEM hold.
- Data port has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- STARVE_MAX, 4, consecutive data grants allowed while fetch waits before fetch is forced; must be >= 1.
- TIMEOUT, 255, maximum cycles in ACC without mem_ack before the access is aborted; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_ready.
- if_addr  in  ADDR_W  fetch address.
- if_rdata  out  DATA_W  fetch data, valid while if_ready.
- if_ready  out  1  one-cycle fetch completion pulse.
- if_stall  out  1  if_req & ~if_ready.
- dm_req  in  1  data request; held until dm_ready.
- dm_we  in  1  1 = write, 0 = read.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  write data.
- dm_rdata  out  DATA_W  read data, valid while dm_ready; 0 for writes.
- dm_ready  out  1  one-cycle data completion pulse.
- dm_stall  out  1  dm_req & ~dm_ready.
- mem_req  out  1  access in progress to memory.
- mem_we  out  1  latched write enable.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data, sampled with mem_ack.
- mem_ack  in  1  memory completion, one cycle, any latency >= 0 cycles after mem_req rises.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset: state IDLE; all outputs 0; starve_cnt = 0; timeout counter = 0; bus_err = 0.
- Reset asserted mid-access drops mem_req immediately and discards the access. No ready pulse is produced for it.
- FSM states: IDLE, ACC, RESP.
- IDLE, grant rule:
  - If dm_req and not (if_req and starve_cnt == STARVE_MAX): grant D.
  - Else if if_req: grant I.
  - Else stay in IDLE.
- On grant: latch addr, we (0 for I), wdata and owner; go to ACC.
- starve_cnt:
  - Increments on a D grant while if_req = 1, saturating at STARVE_MAX.
  - Clears on an I grant.
  - Clears on a D grant while if_req = 0.
- ACC:
  - mem_req = 1 and mem_* hold the latched values for the whole state.
  - On mem_ack: capture mem_rdata (or 0 if we) into the owner's rdata register; go to RESP.
  - Timeout counter increments each ACC cycle. On reaching TIMEOUT without ack: set bus_err, rdata = 0, go to RESP.
- RESP:
  - The owner's ready = 1 for exactly one cycle; mem_req = 0; go to IDLE.
  - The non-owner's rdata register is unchanged.
- Latency: request sampled in IDLE at edge N → mem_req high from cycle N+1 → ack in cycle A → ready in cycle A+1.
  - Minimum request-to-ready is 3 cycles (zero-wait memory).
  - Back-to-back throughput is one access per 3 cycles.
- Simultaneous if_req and dm_req in IDLE: D wins unless the starvation limit is reached.
- A request dropped before ready: the access still completes and the ready pulse is still issued. The requester ignores it.
- mem_ack outside ACC is ignored.
- if_stall and dm_stall are combinational. Every other output is registered.
- bus_err clears only on rst.

Test Plan:
- Reset during ACC (mem_req = 1) → mem_req, ready, bus_err drop to 0 asynchronously; after release, a fresh if_req is served normally.
- Lone fetch: if_req = 1, if_addr = 0x0000_0040; memory acks 2 cycles after mem_req with 0x2008_0005 → mem_addr = 0x40, if_ready pulses 1 cycle later with if_rdata = 0x2008_0005; if_stall high until then.
- Collision: if_req and dm_req (read, 0x100) rise in the same cycle → data served first (mem_addr = 0x100), then fetch; dm_ready precedes if_ready.
- Starvation, STARVE_MAX = 4: if_req and dm_req held continuously → grant order D, D, D, D, I, D…; starve_cnt clears after the I grant.
- Write: dm_we = 1, dm_addr = 0x8, dm_wdata = 0xDEAD_BEEF → mem_we = 1 with those values for the full ACC; dm_ready with dm_rdata = 0.
- Timeout, TIMEOUT = 8: mem_ack never asserted → after 8 ACC cycles bus_err = 1 (sticky), owner ready pulses with rdata = 0, arbiter returns to IDLE and serves the next request.
